// File: rtl/hold_repeat_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hold_pkg: shared state encoding and board-clock defaults             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hold_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SLOW  = 2'd2,
    FAST  = 2'd3
  } hold_state_t;

  // Defaults assume a 100 MHz board clock.
  localparam int c_def_debounce_cycles = 1_000_000;
  localparam int c_def_init_delay      = 50_000_000;
  localparam int c_def_slow_period     = 20_000_000;
  localparam int c_def_fast_period     = 5_000_000;
  localparam int c_def_fast_after      = 4;
  localparam int c_def_step_slow       = 1;
  localparam int c_def_step_fast       = 8;
  localparam int c_def_sw              = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hold_repeat_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce: 2-flop synchronizer plus stable-level counter          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_debounce
  import hold_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_def_debounce_cycles
) (
  input  logic clk,
  input  logic reset,
  input  logic i_button,
  output logic o_level,
  output logic o_rise
);

  localparam int              c_cw   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [c_cw-1:0] r_cnt;
  logic            r_level;
  logic            r_armed;
  logic            r_rise;
  logic            w_differ;
  logic            w_flip;

  // Synchronizer flops are left unreset so they keep tracking the pin.
  always_ff @(posedge clk) begin
    r_sync1 <= i_button;
    r_sync2 <= r_sync1;
  end

  assign w_differ = (r_sync2 != r_level);
  assign w_flip   = w_differ && (r_cnt == c_last);

  // A rise only counts once the button has been seen released since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise  <= w_flip & ~r_level & r_armed;
      r_armed <= r_armed | (~r_level & ~r_sync2);
      if (w_flip) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + c_cw'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/hold_repeat_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hold_repeat_ctrl: press-and-hold auto-repeat step generator          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hold_repeat_ctrl
  import hold_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = c_def_debounce_cycles,
  parameter int INIT_DELAY      = c_def_init_delay,
  parameter int SLOW_PERIOD     = c_def_slow_period,
  parameter int FAST_PERIOD     = c_def_fast_period,
  parameter int FAST_AFTER      = c_def_fast_after,
  parameter int STEP_SLOW       = c_def_step_slow,
  parameter int STEP_FAST       = c_def_step_fast,
  parameter int SW              = c_def_sw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_button,
  output logic          o_step_valid,
  input  logic          i_step_ready,
  output logic [SW-1:0] o_step_size,
  output logic [1:0]    o_hold_level,
  output logic [7:0]    o_drop_count
);

  localparam int c_tmax = max3(INIT_DELAY, SLOW_PERIOD, FAST_PERIOD);
  localparam int c_tw   = ($clog2(c_tmax) < 1) ? 1 : $clog2(c_tmax);
  localparam int c_rw   = $clog2(FAST_AFTER + 1);

  localparam logic [c_tw-1:0] c_init_last  = c_tw'(INIT_DELAY - 1);
  localparam logic [c_tw-1:0] c_slow_last  = c_tw'(SLOW_PERIOD - 1);
  localparam logic [c_tw-1:0] c_fast_last  = c_tw'(FAST_PERIOD - 1);
  localparam logic [c_rw-1:0] c_fast_after = c_rw'(FAST_AFTER);
  localparam logic [SW-1:0]   c_step_slow  = SW'(STEP_SLOW);
  localparam logic [SW-1:0]   c_step_fast  = SW'(STEP_FAST);

  hold_state_t     r_state;
  hold_state_t     w_next;
  logic [c_tw-1:0] r_timer;
  logic [c_rw-1:0] r_rep;
  logic            w_level;
  logic            w_rise;
  logic            w_gen;
  logic [SW-1:0]   w_gen_size;
  logic            r_valid;
  logic [SW-1:0]   r_size;
  logic [7:0]      r_drop;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .i_button(i_button),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Release wins over a repeat that falls due in the same cycle.
  always_comb begin
    w_next     = r_state;
    w_gen      = 1'b0;
    w_gen_size = c_step_slow;
    if (r_state != IDLE && !w_level) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_gen  = 1'b1;
            w_next = FIRST;
          end
        end
        FIRST: begin
          if (r_timer == c_init_last) begin
            w_gen  = 1'b1;
            w_next = (FAST_AFTER <= 1) ? FAST : SLOW;
          end
        end
        SLOW: begin
          if (r_timer == c_slow_last) begin
            w_gen = 1'b1;
            if (r_rep + c_rw'(1) >= c_fast_after) w_next = FAST;
          end
        end
        FAST: begin
          if (r_timer == c_fast_last) begin
            w_gen      = 1'b1;
            w_gen_size = c_step_fast;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_hold_level = r_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer <= '0;
      r_rep   <= '0;
    end else begin
      if (r_state == IDLE || w_next != r_state || w_gen) r_timer <= '0;
      else                                               r_timer <= r_timer + c_tw'(1);

      if (r_state == FIRST && w_gen)     r_rep <= c_rw'(1);
      else if (r_state == SLOW && w_gen) r_rep <= r_rep + c_rw'(1);
      else if (w_next == IDLE)           r_rep <= '0;
    end
  end

  // A new step loads if the slot is free or being retired this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_size  <= '0;
      r_drop  <= '0;
    end else begin
      if (w_gen && (!r_valid || i_step_ready)) begin
        r_valid <= 1'b1;
        r_size  <= w_gen_size;
      end else begin
        if (w_gen && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        if (r_valid && i_step_ready)  r_valid <= 1'b0;
      end
    end
  end

  assign o_step_valid = r_valid;
  assign o_step_size  = r_size;
  assign o_drop_count = r_drop;

endmodule
`default_nettype wire
